// File: rtl/gun_fire_controller.sv
// Purpose : rate-limited gun fire controller with heat lockout and a
//           spawn_req/spawn_ack handshake toward the projectile spawner.
// Latency : all outputs registered; spawn_req/overheated/shooting follow
//           the FSM next state, so they change on the edge after the cause.
// Backpressure: a raised spawn_req is held until spawn_ack, never withdrawn.
//
// Ports:
//   clock        in   system clock, rising-edge
//   resetn       in   asynchronous active-low reset
//   trigger      in   level fire request
//   heat[7:0]    in   current gun heat (unsigned)
//   spawn_ack    in   spawner acceptance, only looked at while requesting
//   spawn_req    out  spawn request (high exactly while in REQ)
//   shooting     out  shoot strobe to the heat counter
//   overheated   out  lockout indicator (high exactly while in LOCKED)
//   shots_fired  out  count of accepted shots, wraps at 16 bits
module gun_fire_controller #(
  parameter logic [23:0] FIRE_PERIOD  = 24'd12_500_000,
  parameter logic [7:0]  HEAT_LOCK    = 8'hF0,
  parameter logic [7:0]  HEAT_RELEASE = 8'h40
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        trigger,
  input  logic [7:0]  heat,
  input  logic        spawn_ack,
  output logic        spawn_req,
  output logic        shooting,
  output logic        overheated,
  output logic [15:0] shots_fired
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT   = 2'd2,
    S_LOCKED = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        spawn_req_q, spawn_req_d;
  logic        shooting_q, shooting_d;
  logic        overheated_q, overheated_d;
  logic [15:0] shots_q, shots_d;
  logic [23:0] period_cnt_q, period_cnt_d;

  // A shot is accepted only when the spawner acks while we are requesting;
  // acks seen in any other state are meaningless and dropped.
  logic shot_accept;
  assign shot_accept = (state_q == S_REQ) && spawn_ack;

  // ------------------------------------------------------------------
  // State register (and all other flops)
  // ------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      spawn_req_q  <= 1'b0;
      shooting_q   <= 1'b0;
      overheated_q <= 1'b0;
      shots_q      <= 16'h0000;
      period_cnt_q <= 24'd0;
    end else begin
      state_q      <= state_d;
      spawn_req_q  <= spawn_req_d;
      shooting_q   <= shooting_d;
      overheated_q <= overheated_d;
      shots_q      <= shots_d;
      period_cnt_q <= period_cnt_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        // Heat check wins over trigger so a hot gun never issues a request.
        if (heat >= HEAT_LOCK) begin
          state_d = S_LOCKED;
        end else if (trigger) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Once raised, the request stays up until the spawner takes it,
        // whatever the trigger or heat do meanwhile.
        if (spawn_ack) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Trigger and heat are ignored here; heat is re-examined in IDLE.
        if (period_cnt_q == 24'd0) begin
          state_d = S_IDLE;
        end
      end
      S_LOCKED: begin
        // Between HEAT_RELEASE and HEAT_LOCK we simply stay put (hysteresis).
        if (heat <= HEAT_RELEASE) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Output / datapath logic
  // ------------------------------------------------------------------
  always_comb begin
    // Registered outputs are decoded from the next state so that they are
    // valid in exactly the cycles the FSM occupies the matching state.
    spawn_req_d  = (state_d == S_REQ);
    overheated_d = (state_d == S_LOCKED);
    shooting_d   = trigger && (state_d != S_LOCKED);

    shots_d = shots_q;
    if (shot_accept) begin
      shots_d = shots_q + 16'd1;   // natural 16-bit wrap
    end

    // Counter loads on acceptance, counts down through WAIT and sits at 0
    // everywhere else. With FIRE_PERIOD=1 it loads 0, so WAIT lasts only
    // its entry cycle.
    period_cnt_d = 24'd0;
    if (shot_accept) begin
      period_cnt_d = FIRE_PERIOD - 24'd1;
    end else if ((state_q == S_WAIT) && (period_cnt_q != 24'd0)) begin
      period_cnt_d = period_cnt_q - 24'd1;
    end
  end

  assign spawn_req   = spawn_req_q;
  assign shooting    = shooting_q;
  assign overheated  = overheated_q;
  assign shots_fired = shots_q;

endmodule

// File: tb/tb_gun_fire_controller.sv
// Randomized scoreboard bench for gun_fire_controller with a behavioural
// model. Stimulus pushes expected outputs tagged with the clock edge they
// belong to; a monitor pops and compares on the falling edge.
module tb_gun_fire_controller;

  localparam int          P    = 4;
  localparam logic [7:0]  LOCK = 8'hF0;
  localparam logic [7:0]  REL  = 8'h40;

  logic        clock;
  logic        resetn;
  logic        trigger;
  logic [7:0]  heat;
  logic        spawn_ack;
  logic        spawn_req;
  logic        shooting;
  logic        overheated;
  logic [15:0] shots_fired;

  gun_fire_controller #(
    .FIRE_PERIOD (24'(P)),
    .HEAT_LOCK   (LOCK),
    .HEAT_RELEASE(REL)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .trigger    (trigger),
    .heat       (heat),
    .spawn_ack  (spawn_ack),
    .spawn_req  (spawn_req),
    .shooting   (shooting),
    .overheated (overheated),
    .shots_fired(shots_fired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // The gun is either requesting, locked, cooling down until a known edge
  // number, or idle. Cooldown is tracked as an absolute edge index.
  bit m_req, m_lock;
  int m_wait_end;   // states produced by edges < m_wait_end are cooldown
  int m_shots;

  typedef struct {
    int          tag;
    bit          sreq;
    bit          shoot;
    bit          ovh;
    logic [15:0] shots;
  } exp_t;
  exp_t q[$];

  task automatic model_reset();
    m_req = 0; m_lock = 0; m_wait_end = 0; m_shots = 0;
  endtask

  // Apply inputs seen during the cycle that ends with edge e.
  task automatic model_edge(input bit t, input logic [7:0] h, input bit a, input int e);
    if (m_req) begin
      if (a) begin
        m_req = 0;
        m_shots = (m_shots + 1) % 65536;
        m_wait_end = e + P;
      end
    end else if (m_lock) begin
      if (h <= REL) m_lock = 0;
    end else if ((e - 1) < m_wait_end) begin
      // cooling down: inputs have no effect
    end else if (h >= LOCK) begin
      m_lock = 1;
    end else if (t) begin
      m_req = 1;
    end
  endtask

  function automatic exp_t model_out(input int tag, input bit t);
    exp_t x;
    x.tag   = tag;
    x.sreq  = m_req;
    x.ovh   = m_lock;
    x.shoot = t && !m_lock;
    x.shots = 16'(m_shots);
    return x;
  endfunction

  // Called at posedge+1: drive inputs, predict the next edge, advance.
  task automatic step(input bit t, input logic [7:0] h, input bit a);
    trigger = t; heat = h; spawn_ack = a;
    model_edge(t, h, a, cyc + 1);
    q.push_back(model_out(cyc + 1, t));
    @(posedge clock); #1;
  endtask

  function automatic bit model_idle();
    return !m_req && !m_lock && !(cyc < m_wait_end);
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clock);
      while (q.size() > 0 && q[0].tag < cyc) begin
        total++; bad++;
        $display("FAIL stale_expect tag=%0d cycle=%0d", q[0].tag, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].tag == cyc) begin
        exp_t x;
        x = q.pop_front();
        chk("spawn_req",   32'(spawn_req),   32'(x.sreq));
        chk("shooting",    32'(shooting),    32'(x.shoot));
        chk("overheated",  32'(overheated),  32'(x.ovh));
        chk("shots_fired", 32'(shots_fired), 32'(x.shots));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int hv;
    int n;
    resetn = 1'b0; trigger = 1'b0; heat = 8'h00; spawn_ack = 1'b0;
    model_reset();
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("rst_spawn_req",  32'(spawn_req),   32'd0);
    chk("rst_shooting",   32'(shooting),    32'd0);
    chk("rst_overheated", 32'(overheated),  32'd0);
    chk("rst_shots",      32'(shots_fired), 32'd0);
    resetn = 1'b1;

    // Single shot: ack on the third REQ cycle, then release the trigger.
    step(0, 8'h10, 0);
    step(1, 8'h10, 0);          // -> REQ
    step(1, 8'h10, 0);          // REQ cycle 1
    step(1, 8'h10, 0);          // REQ cycle 2
    step(1, 8'h10, 1);          // REQ cycle 3, ack
    for (int i = 0; i < 8; i++) step(0, 8'h10, 0);
    chk("single_shot_count", 32'(shots_fired), 32'd1);

    // Drive to a REQ cycle with shots_fired=5, then reset between edges.
    n = 0;
    while (!(m_req && m_shots == 5) && n < 200) begin
      step(1, 8'h10, m_req ? 1'b0 : 1'b1);
      if (m_req && m_shots == 5) break;
      step(1, 8'h10, 1);
      n++;
    end
    if (!(m_req && m_shots == 5)) begin
      total++; bad++;
      $display("FAIL reach_shot5: model never reached REQ with 5 shots");
    end
    chk("pre_rst_spawn_req", 32'(spawn_req),   32'd1);
    chk("pre_rst_shots",     32'(shots_fired), 32'd5);
    #2 resetn = 1'b0;
    #1;
    chk("arst_spawn_req",  32'(spawn_req),   32'd0);
    chk("arst_shooting",   32'(shooting),    32'd0);
    chk("arst_overheated", 32'(overheated),  32'd0);
    chk("arst_shots",      32'(shots_fired), 32'd0);
    model_reset();
    foreach (q[i]) if (q[i].tag == cyc) q[i] = model_out(cyc, 1'b0);
    trigger = 1'b1; spawn_ack = 1'b1;
    q.push_back(model_out(cyc + 1, 1'b0));
    @(posedge clock); #1;
    resetn = 1'b1;

    // Sustained fire from reset: trigger held, ack tied high.
    n = 0;
    while (m_shots < 10 && n < 200) begin
      step(1, 8'h10, 1);
      n++;
    end
    chk("sustained_count", 32'(shots_fired), 32'd10);
    for (int i = 0; i < 8; i++) step(1, 8'h10, 1);

    // Get back to idle, then lockout hysteresis.
    for (int i = 0; i < 12; i++) step(0, 8'h10, 1);
    step(0, 8'hF0, 0);          // -> LOCKED
    step(1, 8'hF8, 0);
    step(1, 8'h80, 0);
    step(1, 8'h41, 0);          // still LOCKED
    step(1, 8'h40, 0);          // -> IDLE
    step(0, 8'h10, 0);

    // No withdrawal: request raised, then trigger dropped and heat maxed.
    step(1, 8'h10, 0);          // -> REQ
    step(0, 8'hFF, 0);
    step(0, 8'hFF, 0);
    step(0, 8'hFF, 0);
    step(0, 8'hFF, 1);          // ack -> WAIT
    for (int i = 0; i < 7; i++) step(0, 8'hFF, 0);
    chk("post_wait_locked", 32'(overheated), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 8'h20, 0);

    // Randomized traffic with a wandering heat value.
    hv = 100;
    for (int i = 0; i < 2500; i++) begin
      hv = hv + int'($urandom_range(0, 48)) - 24;
      if (hv < 0) hv = 0;
      if (hv > 255) hv = 255;
      step(($urandom_range(0, 9) < 7), 8'(hv), ($urandom_range(0, 9) < 4));
    end

    // Wrap: park in IDLE, preset the counter to FFFF, fire once more.
    n = 0;
    while (!model_idle() && n < 50) begin
      step(0, 8'h00, 1);
      n++;
    end
    step(0, 8'h00, 0);
    @(negedge clock); #1;
    force dut.shots_q = 16'hFFFF;
    m_shots = 16'hFFFF;
    foreach (q[i]) if (q[i].tag > cyc) q[i].shots = 16'hFFFF;
    @(posedge clock); #1;
    release dut.shots_q;
    n = 0;
    while (m_shots != 0 && n < 20) begin
      step(1, 8'h00, 1);
      n++;
    end
    chk("wrap_count", 32'(shots_fired), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0);

    @(negedge clock); #1;
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL queue_drain: %0d expectations left", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
